// File: rtl/slow_frame_tx.sv
// Slow-down request frame generator: emits fixed 60-byte frames while the local FIFO sits above a watermark.
// Optional SLOWFRAME_SEQNUM_EN: byte 19 carries a wrapping per-frame sequence number instead of 8'h00.
module slow_frame_tx #(
  parameter logic [47:0] DST_MAC        = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC        = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE      = 16'h88B5,
  parameter logic [31:0] HIGH_THRESH    = 32'd1024,
  parameter logic [31:0] LOW_THRESH     = 32'd256,
  parameter logic [16:0] HOLDOFF_CYCLES = 17'd4000
) (
  input  logic        CPUCLK,
  input  logic        bus_struct_resetn,
  input  logic        Enable,
  input  logic [31:0] FifoFillAmt,
  output logic [7:0]  TxData,
  output logic        TxValid,
  output logic        TxLast,
  input  logic        TxReady,
  output logic        Active,
  output logic [15:0] FrameCount,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  byte_idx_q, byte_idx_d;
  logic [16:0] hold_cnt_q, hold_cnt_d;
  logic [31:0] snap_q, snap_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        active_q, active_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_last_q, tx_last_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  seq_byte;
  logic        accept;

`ifdef SLOWFRAME_SEQNUM_EN
  logic [7:0] seq_q, seq_d;
  assign seq_byte = seq_q;
`else
  assign seq_byte = 8'h00;
`endif

  function automatic logic [7:0] frame_byte(input logic [5:0] idx, input logic [31:0] snap,
                                            input logic [7:0] seq);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      6'd0:  b = DST_MAC[47:40];
      6'd1:  b = DST_MAC[39:32];
      6'd2:  b = DST_MAC[31:24];
      6'd3:  b = DST_MAC[23:16];
      6'd4:  b = DST_MAC[15:8];
      6'd5:  b = DST_MAC[7:0];
      6'd6:  b = SRC_MAC[47:40];
      6'd7:  b = SRC_MAC[39:32];
      6'd8:  b = SRC_MAC[31:24];
      6'd9:  b = SRC_MAC[23:16];
      6'd10: b = SRC_MAC[15:8];
      6'd11: b = SRC_MAC[7:0];
      6'd12: b = ETHERTYPE[15:8];
      6'd13: b = ETHERTYPE[7:0];
      6'd14: b = 8'h01;
      6'd15: b = snap[31:24];
      6'd16: b = snap[23:16];
      6'd17: b = snap[15:8];
      6'd18: b = snap[7:0];
      6'd19: b = seq;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Handshake: a byte transfers on any rising edge where TxValid & TxReady; while TxReady is low
  // TxData/TxLast hold, and once TxValid rises it stays high until byte 59 is accepted.
  assign accept = tx_valid_q & TxReady;

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    hold_cnt_d  = hold_cnt_q;
    snap_d      = snap_q;
    frame_cnt_d = frame_cnt_q;
`ifdef SLOWFRAME_SEQNUM_EN
    seq_d       = seq_q;
`endif
    active_d = (FifoFillAmt >= HIGH_THRESH) ? 1'b1 :
               (FifoFillAmt < LOW_THRESH)   ? 1'b0 : active_q;

    case (state_q)
      ST_IDLE: begin
        if (active_q && Enable) begin
          state_d    = ST_SEND;
          byte_idx_d = 6'd0;
          snap_d     = FifoFillAmt;
        end
      end
      ST_SEND: begin
        if (accept) begin
          if (byte_idx_q == 6'd59) begin
            state_d    = ST_HOLDOFF;
            hold_cnt_d = HOLDOFF_CYCLES - 17'd1;
            if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef SLOWFRAME_SEQNUM_EN
            seq_d = seq_q + 8'd1;
`endif
          end else begin
            byte_idx_d = byte_idx_q + 6'd1;
          end
        end
      end
      ST_HOLDOFF: begin
        if (hold_cnt_q == 17'd0) state_d = ST_IDLE;
        else                     hold_cnt_d = hold_cnt_q - 17'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from next-state values so the first byte appears with TxValid.
    tx_valid_d = (state_d == ST_SEND);
    tx_data_d  = tx_valid_d ? frame_byte(byte_idx_d, snap_d, seq_byte) : 8'h00;
    tx_last_d  = tx_valid_d && (byte_idx_d == 6'd59);
  end

  always_ff @(posedge CPUCLK or negedge bus_struct_resetn) begin
    if (!bus_struct_resetn) begin
      state_q     <= ST_IDLE;
      byte_idx_q  <= 6'd0;
      hold_cnt_q  <= 17'd0;
      snap_q      <= 32'd0;
      frame_cnt_q <= 16'd0;
      active_q    <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      tx_data_q   <= 8'h00;
`ifdef SLOWFRAME_SEQNUM_EN
      seq_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      snap_q      <= snap_d;
      frame_cnt_q <= frame_cnt_d;
      active_q    <= active_d;
      tx_valid_q  <= tx_valid_d;
      tx_last_q   <= tx_last_d;
      tx_data_q   <= tx_data_d;
`ifdef SLOWFRAME_SEQNUM_EN
      seq_q       <= seq_d;
`endif
    end
  end

  assign TxData     = tx_data_q;
  assign TxValid    = tx_valid_q;
  assign TxLast     = tx_last_q;
  assign Active     = active_q;
  assign FrameCount = frame_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_slow_frame_tx.sv
// Bench for slow_frame_tx: frame-level reference model with per-cycle compare plus directed literal checks.
`timescale 1ns/1ps
module tb_slow_frame_tx;
  localparam int          H      = 40;
  localparam logic [31:0] HIGH   = 32'd1024;
  localparam logic [31:0] LOW    = 32'd256;
  localparam logic [47:0] DST    = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC    = 48'h0200_0000_0001;
  localparam logic [15:0] ETYPE  = 16'h88B5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        tx_ready = 1'b1;
  logic [31:0] fill = 32'd0;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_last, active;
  logic [15:0] frame_count;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;

  // Reference model state
  logic [7:0]  exp_q[$];
  logic [7:0]  acc_q[$];
  logic        m_active = 1'b0;
  logic [15:0] m_frames = 16'd0;
  logic [7:0]  m_seq = 8'd0;
  longint      cyc = 0;
  longint      m_next_ok = 0;
  logic [7:0]  frm [60];

  always #5 clk = ~clk;

  slow_frame_tx #(.HOLDOFF_CYCLES(17'(H))) dut (
    .CPUCLK(clk), .bus_struct_resetn(rst_n), .Enable(enable), .FifoFillAmt(fill),
    .TxData(tx_data), .TxValid(tx_valid), .TxLast(tx_last), .TxReady(tx_ready),
    .Active(active), .FrameCount(frame_count), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_frame(input logic [31:0] snap, input logic [7:0] seq);
    logic [159:0] hdr;
    hdr = {DST, SRC, ETYPE, 8'h01, snap, seq};
    for (int i = 0; i < 60; i++) exp_q.push_back(i < 20 ? hdr[8*(19-i) +: 8] : 8'h00);
  endfunction

  // Model: one frame in flight, earliest restart H+1 edges after the last accept, hysteresis on fill.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_active = 1'b0; m_frames = 16'd0; m_seq = 8'd0; cyc = 0; m_next_ok = 0;
    end else begin
      if (exp_q.size() != 0) begin
        if (tx_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            if (m_frames != 16'hFFFF) m_frames = m_frames + 16'd1;
            m_seq = m_seq + 8'd1;
            m_next_ok = cyc + H + 1;
          end
        end
      end else if (cyc >= m_next_ok && m_active && enable) begin
`ifdef SLOWFRAME_SEQNUM_EN
        push_frame(fill, m_seq);
`else
        push_frame(fill, 8'h00);
`endif
      end
      m_active = (fill >= HIGH) ? 1'b1 : (fill < LOW) ? 1'b0 : m_active;
      cyc++;
    end
  end

  always @(posedge clk) begin
    if (rst_n && tx_valid && tx_ready) acc_q.push_back(tx_data);
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_valid", tx_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("cmp_data", tx_data, exp_q[0]);
        chk("cmp_last", tx_last, exp_q.size() == 1);
      end else begin
        chk("cmp_data_idle", tx_data, 0);
        chk("cmp_last_idle", tx_last, 0);
      end
      chk("cmp_active", active, m_active);
      chk("cmp_frame_count", frame_count, m_frames);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int limit, input string name);
    int n = 0;
    while (!tx_valid && n < limit) begin tick(); n++; end
    chk(name, tx_valid, 1);
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (tx_valid && n < limit) begin tick(); n++; end
    chk(name, tx_valid, 0);
  endtask

  initial begin
    int gap, nv, n;
    logic [7:0] exp19;
    fill = 32'd2000; enable = 1'b1; tx_ready = 1'b1;
    do_reset();
    chk("reset_valid", tx_valid, 0);
    chk("reset_active", active, 0);
    chk("reset_fc", frame_count, 0);

    // Case 1: Active after one edge, bytes in cycles 2..61
    tick();
    chk("t1_active_c1", active, 1);
    chk("t1_valid_c1", tx_valid, 0);
    tick();
    for (int i = 0; i < 60; i++) begin
      frm[i] = tx_data;
      chk("t1_valid", tx_valid, 1);
      chk("t1_last", tx_last, i == 59);
      tick();
    end
    chk("t1_valid_after", tx_valid, 0);
    chk("t1_fc", frame_count, 1);
    chk("t1_b0", frm[0], 8'hFF);
    chk("t1_b6", frm[6], 8'h02);
    chk("t1_b11", frm[11], 8'h01);
    chk("t1_b12", frm[12], 8'h88);
    chk("t1_b13", frm[13], 8'hB5);
    chk("t1_b14", frm[14], 8'h01);
    chk("t1_b15", frm[15], 8'h00);
    chk("t1_b16", frm[16], 8'h00);
    chk("t1_b17", frm[17], 8'h07);
    chk("t1_b18", frm[18], 8'hD0);
    chk("t1_b19", frm[19], 8'h00);
    chk("t1_b40", frm[40], 8'h00);

    // Case 2: idle gap between TxLast and next first byte is H holdoff cycles plus the IDLE cycle
    gap = 0;
    while (!tx_valid && gap < 10 * H) begin gap++; tick(); end
    chk("t2_gap", gap, H + 1);
    wait_idle(200, "t2_frame_end");

    // Case 3: random backpressure, same byte sequence
    acc_q.delete();
    rand_ready = 1'b1;
    n = 0;
    while (acc_q.size() < 60 && n < 2000) begin tick(); n++; end
    rand_ready = 1'b0;
    tx_ready = 1'b1;
    chk("t3_count", acc_q.size(), 60);
`ifdef SLOWFRAME_SEQNUM_EN
    exp19 = 8'd2;
`else
    exp19 = 8'd0;
`endif
    if (acc_q.size() == 60) begin
      for (int i = 0; i < 60; i++) chk("t3_byte", acc_q[i], (i == 19) ? exp19 : frm[i]);
    end
    wait_idle(10, "t3_frame_end");

    // Case 4: fill drops during SEND; frame completes, no follow-up frame
    wait_valid(10 * H, "t4_start");
    repeat (10) tick();
    fill = 32'd256;
    tick();
    chk("t4_active_at_low", active, 1);
    repeat (3) tick();
    fill = 32'd255;
    tick();
    chk("t4_active_cleared", active, 0);
    chk("t4_still_sending", tx_valid, 1);
    wait_idle(100, "t4_frame_end");
    chk("t4_fc", frame_count, 4);
    nv = 0;
    for (int i = 0; i < 3 * H; i++) begin if (tx_valid) nv++; tick(); end
    chk("t4_no_frame", nv, 0);

    // Case 5: reset mid-frame
    fill = 32'd2000;
    wait_valid(10, "t5_start");
    repeat (30) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid_async", tx_valid, 0);
    chk("t5_data_async", tx_data, 0);
    chk("t5_active_async", active, 0);
    chk("t5_fc_async", frame_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_valid(10, "t5_restart");
    chk("t5_first_byte", tx_data, 8'hFF);
    chk("t5_fc_during", frame_count, 0);
    n = 0;
    while (!tx_last && n < 100) begin tick(); n++; end
    chk("t5_last_seen", tx_last, 1);
    chk("t5_fc_at_last", frame_count, 0);
    tick();
    chk("t5_fc_after", frame_count, 1);

    // Case 6: byte 19 across 257 frames
    do_reset();
    for (int f = 0; f < 257; f++) begin
      acc_q.delete();
      n = 0;
      while (acc_q.size() < 60 && n < 300) begin tick(); n++; end
      chk("t6_count", acc_q.size(), 60);
`ifdef SLOWFRAME_SEQNUM_EN
      exp19 = 8'(f % 256);
`else
      exp19 = 8'd0;
`endif
      if (acc_q.size() == 60) chk("t6_seq", acc_q[19], exp19);
    end
    chk("t6_fc", frame_count, 257);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
